rr_arb_mux_n: RTL and testbench

//  Parametrised N-channel, WIDTH-bit arbitrating multiplexer with a registered

---
 rtl/rr_arb_mux_n.sv | 117 +++++++++++
 tb/tb_rr_arb_mux_n.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux_n.sv
// rr_arb_mux_n
//   N-channel, WIDTH-bit arbitrating multiplexer with a registered output
//   stage. Several valid/ready producers share one valid/ready consumer. The
//   arbiter is round-robin (RR_EN=1) or fixed lowest-index priority (RR_EN=0).
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   [NUM_CH]        per-channel request
//   in_data    in   [NUM_CH*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//   in_ready   out  [NUM_CH]        per-channel accept, one-hot or zero
//   out_valid  out  output register holds a word
//   out_data   out  [WIDTH]         registered data
//   out_ch     out  [CH_W]          source channel of out_data
//   out_ready  in   consumer accepts out_data this cycle
module rr_arb_mux_n #(
   parameter int NUM_CH = 8,
   parameter int WIDTH  = 16,
   parameter bit RR_EN  = 1'b1,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [CH_W-1:0]         out_ch,
   input  logic                    out_ready
);

   logic              valid_q, valid_d;
   logic [WIDTH-1:0]  data_q,  data_d;
   logic [CH_W-1:0]   ch_q,    ch_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;   // last granted channel

   logic              load_en;
   logic              any_req;
   logic [CH_W-1:0]   grant_idx;
   logic [NUM_CH-1:0] grant;
   logic              xfer;

   // Output register can take a new word when empty or being drained.
   assign load_en = !valid_q | out_ready;

   // Arbitration: search starts just after the last grant and wraps; only
   // indices below NUM_CH are ever visited, so non-power-of-two sizes never
   // produce an out-of-range grant.
   always_comb begin
      int idx;
      any_req   = 1'b0;
      grant_idx = '0;
      idx       = 0;
      if (RR_EN) begin
         for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!any_req && in_valid[idx]) begin
               any_req   = 1'b1;
               grant_idx = CH_W'(idx);
            end
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (!any_req && in_valid[k]) begin
               any_req   = 1'b1;
               grant_idx = CH_W'(k);
            end
         end
      end
   end

   always_comb begin
      grant = '0;
      if (any_req) grant[grant_idx] = 1'b1;
   end

   // Gated by rst so no producer sees an accept while the block is held in reset.
   assign in_ready = (load_en && !rst) ? grant : '0;
   assign xfer     = any_req & load_en;

   always_comb begin
      valid_d  = valid_q;
      data_d   = data_q;
      ch_d     = ch_q;
      rr_ptr_d = rr_ptr_q;
      if (xfer) begin
         valid_d  = 1'b1;
         data_d   = in_data[grant_idx*WIDTH +: WIDTH];
         ch_d     = grant_idx;
         if (RR_EN) rr_ptr_d = grant_idx;
      end else if (valid_q && out_ready) begin
         // Drained with nothing new: data/ch keep their last values.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         ch_q     <= '0;
         rr_ptr_q <= CH_W'(NUM_CH - 1);   // channel 0 wins the first round
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         ch_q     <= ch_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_ch    = ch_q;

endmodule

// File: tb/tb_rr_arb_mux_n.sv
// tb_rr_arb_mux_n
//   Runs three arbiter configurations in lockstep: 8x16 round-robin,
//   8x16 fixed priority and 5x9 round-robin. A transaction-level model
//   (priority by rotating distance from the last grant) predicts in_ready and
//   the output register every cycle; directed scenarios add fixed expectations.
module tb_rr_arb_mux_n;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Stimulus per configuration (u = 0:8 RR, 1:8 fixed, 2:5 RR)
   logic [7:0]  vld [3];
   logic [15:0] dat [3][8];
   logic        ordy [3];

   logic [127:0] a_din, b_din;
   logic [44:0]  c_din;
   logic [7:0]   a_rdy, b_rdy;
   logic [4:0]   c_rdy;
   logic         a_ov, b_ov, c_ov;
   logic [15:0]  a_od, b_od;
   logic [8:0]   c_od;
   logic [2:0]   a_ch, b_ch, c_ch;

   always_comb begin
      a_din = '0;
      b_din = '0;
      c_din = '0;
      for (int i = 0; i < 8; i++) begin
         a_din[i*16 +: 16] = dat[0][i];
         b_din[i*16 +: 16] = dat[1][i];
      end
      for (int i = 0; i < 5; i++) c_din[i*9 +: 9] = dat[2][i][8:0];
   end

   rr_arb_mux_n #(.NUM_CH(8), .WIDTH(16), .RR_EN(1'b1)) u_a (
      .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(a_din), .in_ready(a_rdy),
      .out_valid(a_ov), .out_data(a_od), .out_ch(a_ch), .out_ready(ordy[0]));
   rr_arb_mux_n #(.NUM_CH(8), .WIDTH(16), .RR_EN(1'b0)) u_b (
      .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(b_din), .in_ready(b_rdy),
      .out_valid(b_ov), .out_data(b_od), .out_ch(b_ch), .out_ready(ordy[1]));
   rr_arb_mux_n #(.NUM_CH(5), .WIDTH(9), .RR_EN(1'b1)) u_c (
      .clk(clk), .rst(rst), .in_valid(vld[2][4:0]), .in_data(c_din), .in_ready(c_rdy),
      .out_valid(c_ov), .out_data(c_od), .out_ch(c_ch), .out_ready(ordy[2]));

   int nchk = 0;
   int nfail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int mv [3], md [3], mch [3], mptr [3];

   function automatic int nch(input int u);  return (u == 2) ? 5 : 8;          endfunction
   function automatic bit rre(input int u);  return (u != 1);                  endfunction
   function automatic int dmask(input int u); return (u == 2) ? 'h1FF : 'hFFFF; endfunction

   // Winner = requester with the smallest rotating distance from the last
   // grant (round-robin) or the smallest index (fixed priority).
   function automatic int mgrant(input int u, input logic [7:0] v);
      int best = -1;
      int bd = 1000;
      for (int c = 0; c < nch(u); c++) begin
         if (v[c]) begin
            int d = rre(u) ? (c - mptr[u] - 1 + 2*nch(u)) % nch(u) : c;
            if (d < bd) begin bd = d; best = c; end
         end
      end
      return best;
   endfunction

   task automatic mreset();
      for (int u = 0; u < 3; u++) begin
         mv[u] = 0; md[u] = 0; mch[u] = 0; mptr[u] = nch(u) - 1;
      end
   endtask

   function automatic logic [31:0] o_rdy(input int u);
      return (u == 0) ? 32'(a_rdy) : (u == 1) ? 32'(b_rdy) : 32'(c_rdy);
   endfunction
   function automatic logic [31:0] o_ov(input int u);
      return (u == 0) ? 32'(a_ov) : (u == 1) ? 32'(b_ov) : 32'(c_ov);
   endfunction
   function automatic logic [31:0] o_od(input int u);
      return (u == 0) ? 32'(a_od) : (u == 1) ? 32'(b_od) : 32'(c_od);
   endfunction
   function automatic logic [31:0] o_ch(input int u);
      return (u == 0) ? 32'(a_ch) : (u == 1) ? 32'(b_ch) : 32'(c_ch);
   endfunction

   // Called just after a falling edge with inputs applied: checks all three
   // DUTs against the model, then advances the model across the rising edge.
   task automatic step();
      int g [3];
      int ld [3];
      logic [31:0] er;
      #1;
      for (int u = 0; u < 3; u++) begin
         g[u]  = mgrant(u, vld[u]);
         ld[u] = (mv[u] == 0) || ordy[u];
         er    = (rst || !ld[u] || g[u] < 0) ? 32'd0 : (32'd1 << g[u]);
         chk($sformatf("in_ready%0d", u), o_rdy(u), er);
         chk($sformatf("out_valid%0d", u), o_ov(u), 32'(mv[u]));
         chk($sformatf("out_data%0d", u), o_od(u), 32'(md[u]));
         chk($sformatf("out_ch%0d", u), o_ch(u), 32'(mch[u]));
      end
      @(posedge clk);
      for (int u = 0; u < 3; u++) begin
         if (rst) begin
            mv[u] = 0; md[u] = 0; mch[u] = 0; mptr[u] = nch(u) - 1;
         end else if (ld[u] && g[u] >= 0) begin
            mv[u]  = 1;
            md[u]  = int'(dat[u][g[u]]) & dmask(u);
            mch[u] = g[u];
            if (rre(u)) mptr[u] = g[u];
         end else if (mv[u] != 0 && ordy[u]) begin
            mv[u] = 0;
         end
      end
      @(negedge clk);
   endtask

   // Asynchronous reset pulse between clock edges.
   task automatic async_rst();
      #2 rst = 1'b1;
      #1;
      for (int u = 0; u < 3; u++) begin
         chk($sformatf("arst_valid%0d", u), o_ov(u), 32'd0);
         chk($sformatf("arst_ready%0d", u), o_rdy(u), 32'd0);
      end
      mreset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      mreset();
      for (int u = 0; u < 3; u++) begin
         vld[u] = 8'hFF; ordy[u] = 1'b1;
         for (int i = 0; i < 8; i++) dat[u][i] = 16'hA000 + 16'(i);
      end
      @(negedge clk);

      // Reset with every channel requesting
      step();
      chk("rst_ready", o_rdy(0), 32'd0);
      chk("rst_data", o_od(0), 32'd0);
      step();
      rst = 1'b0;

      // Round-robin sweep (a), fixed priority starvation (b), odd size sweep (c)
      vld[1] = 8'b1000_0110;
      vld[2] = 8'h1F;
      for (int k = 1; k <= 11; k++) begin
         step();
         chk("rr_ch", o_ch(0), 32'((k - 1) % 8));
         chk("rr_data", o_od(0), 32'h0000A000 + 32'((k - 1) % 8));
         chk("rr_valid", o_ov(0), 32'd1);
         chk("fp_ch", o_ch(1), 32'd1);
         chk("odd_ch", o_ch(2), 32'((k - 1) % 5));
      end

      // Backpressure: hold a ch3 word while other channels keep requesting
      vld[0] = 8'b0000_1000;
      dat[0][3] = 16'hBEEF;
      step();
      vld[0] = 8'hFF;
      ordy[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("bp_data", o_od(0), 32'h0000BEEF);
         chk("bp_ch", o_ch(0), 32'd3);
         chk("bp_ready", o_rdy(0), 32'd0);
      end

      // Skip and wrap from a last grant of ch6
      ordy[0] = 1'b1;
      vld[0] = 8'b0100_0000;
      step();
      vld[0] = 8'b0010_0001;
      step(); chk("wrap_ch_a", o_ch(0), 32'd0);
      step(); chk("wrap_ch_b", o_ch(0), 32'd5);
      step(); chk("wrap_ch_c", o_ch(0), 32'd0);

      // Reset mid-stream, then ch0 is first after release on the odd-size block
      vld[2] = 8'h1F;
      ordy[2] = 1'b1;
      step();
      step();
      async_rst();
      step();
      chk("post_rst_ch", o_ch(2), 32'd0);
      chk("post_rst_valid", o_ov(2), 32'd1);

      // Randomized traffic with occasional reset pulses
      for (int n = 0; n < 600; n++) begin
         for (int u = 0; u < 3; u++) begin
            case ($urandom_range(0, 3))
               0:       vld[u] = 8'($urandom) & 8'($urandom);
               1:       vld[u] = 8'(1 << $urandom_range(0, 7));
               2:       ;  // hold
               default: vld[u] = 8'($urandom);
            endcase
            for (int i = 0; i < 8; i++) dat[u][i] = 16'($urandom);
            ordy[u] = ($urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 79) == 0) async_rst();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
